// File: rtl/cq_poller.sv
// Completion-queue poller: reads one CQ entry at a time, emits completions whose phase
// bit matches, then rings the CQ head doorbell before polling the next slot.
module cq_poller #(
    parameter int OUTSTANDING   = 16,
    parameter int CQ_ADDR_WIDTH = 8,
    parameter int POLL_GAP      = 8,
    parameter int DB_ADDR       = 1012
) (
    input  logic                           clk,
    input  logic                           rstn,

    output logic [CQ_ADDR_WIDTH-1:0]       cq_araddr,
    output logic [7:0]                     cq_arlen,
    output logic [2:0]                     cq_arsize,
    output logic [1:0]                     cq_arburst,
    output logic                           cq_arvalid,
    input  logic                           cq_arready,

    input  logic [127:0]                   cq_rdata,
    input  logic [1:0]                     cq_rresp,
    input  logic                           cq_rlast,
    input  logic                           cq_rvalid,
    output logic                           cq_rready,

    output logic [31:0]                    db_awaddr,
    output logic [7:0]                     db_awlen,
    output logic [2:0]                     db_awsize,
    output logic [1:0]                     db_awburst,
    output logic                           db_awvalid,
    input  logic                           db_awready,

    output logic [127:0]                   db_wdata,
    output logic [15:0]                    db_wstrb,
    output logic                           db_wlast,
    output logic                           db_wvalid,
    input  logic                           db_wready,

    input  logic [1:0]                     db_bresp,
    input  logic                           db_bvalid,
    output logic                           db_bready,

    output logic                           cpl_valid,
    input  logic                           cpl_ready,
    output logic [15:0]                    cpl_cid,
    output logic [14:0]                    cpl_status,

    output logic [$clog2(OUTSTANDING)-1:0] cqdb_sqhead,
    output logic [$clog2(OUTSTANDING)-1:0] cqdb_cqhead,
    output logic                           err
);

    localparam int IW = $clog2(OUTSTANDING);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        POLL_AR,
        POLL_R,
        GAP,
        CPL,
        DB,
        DB_B
    } state_t;

    state_t          r_state;
    logic            r_phase;
    logic [IW-1:0]   r_cqhead;
    logic [IW-1:0]   r_sqhead;
    logic [IW-1:0]   r_sq_cap;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_aw_done;
    logic            r_w_done;
    logic            r_err;

    logic            r_cq_arvalid;
    logic            r_cq_rready;
    logic            r_db_awvalid;
    logic            r_db_wvalid;
    logic            r_db_bready;
    logic            r_cpl_valid;
    logic [15:0]     r_cpl_cid;
    logic [14:0]     r_cpl_status;

    logic            w_aw_fin;
    logic            w_w_fin;
    logic            w_unused;

    // A channel counts as finished if it already handshook or does so this cycle.
    assign w_aw_fin = r_aw_done | (r_db_awvalid & db_awready);
    assign w_w_fin  = r_w_done  | (r_db_wvalid  & db_wready);

    // Entry fields this block does not consume.
    assign w_unused = ^{cq_rlast, cq_rdata[95:64+IW], cq_rdata[63:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= POLL_AR;
            r_phase      <= 1'b1;
            r_cqhead     <= '0;
            r_sqhead     <= '0;
            r_sq_cap     <= '0;
            r_gap_cnt    <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_err        <= 1'b0;
            r_cq_arvalid <= 1'b0;
            r_cq_rready  <= 1'b0;
            r_db_awvalid <= 1'b0;
            r_db_wvalid  <= 1'b0;
            r_db_bready  <= 1'b0;
            r_cpl_valid  <= 1'b0;
            r_cpl_cid    <= '0;
            r_cpl_status <= '0;
        end else begin
            case (r_state)
                POLL_AR: begin
                    if (!r_cq_arvalid) begin
                        r_cq_arvalid <= 1'b1;
                    end else if (cq_arready) begin
                        r_cq_arvalid <= 1'b0;
                        r_cq_rready  <= 1'b1;
                        r_state      <= POLL_R;
                    end
                end

                POLL_R: begin
                    if (r_cq_rready && cq_rvalid) begin
                        r_cq_rready  <= 1'b0;
                        r_cpl_cid    <= cq_rdata[111:96];
                        r_cpl_status <= cq_rdata[127:113];
                        r_sq_cap     <= cq_rdata[64 +: IW];
                        if (|cq_rresp) begin
                            r_err <= 1'b1;
                        end
                        if (cq_rdata[112] == r_phase) begin
                            r_cpl_valid <= 1'b1;
                            r_state     <= CPL;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
                        r_cq_arvalid <= 1'b1;
                        r_state      <= POLL_AR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                CPL: begin
                    if (r_cpl_valid && cpl_ready) begin
                        r_cpl_valid  <= 1'b0;
                        r_sqhead     <= r_sq_cap;
                        r_cqhead     <= r_cqhead + 1'b1;
                        if (r_cqhead == IW'(OUTSTANDING - 1)) begin
                            r_phase <= ~r_phase;
                        end
                        r_db_awvalid <= 1'b1;
                        r_db_wvalid  <= 1'b1;
                        r_state      <= DB;
                    end
                end

                DB: begin
                    if (r_db_awvalid && db_awready) begin
                        r_db_awvalid <= 1'b0;
                        r_aw_done    <= 1'b1;
                    end
                    if (r_db_wvalid && db_wready) begin
                        r_db_wvalid <= 1'b0;
                        r_w_done    <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_db_bready <= 1'b1;
                        r_state     <= DB_B;
                    end
                end

                DB_B: begin
                    if (r_db_bready && db_bvalid) begin
                        r_db_bready <= 1'b0;
                        if (|db_bresp) begin
                            r_err <= 1'b1;
                        end
                        r_cq_arvalid <= 1'b1;
                        r_state      <= POLL_AR;
                    end
                end

                default: begin
                    r_state <= POLL_AR;
                end
            endcase
        end
    end

    // Payloads derive from registers that only change outside their own valid window.
    assign cq_araddr   = CQ_ADDR_WIDTH'({r_cqhead, 4'b0000});
    assign cq_arlen    = 8'd0;
    assign cq_arsize   = 3'd4;
    assign cq_arburst  = 2'd1;
    assign cq_arvalid  = r_cq_arvalid;
    assign cq_rready   = r_cq_rready;

    assign db_awaddr   = 32'(DB_ADDR);
    assign db_awlen    = 8'd0;
    assign db_awsize   = 3'd2;
    assign db_awburst  = 2'd1;
    assign db_awvalid  = r_db_awvalid;

    assign db_wdata    = {64'd0, 32'(r_cqhead), 32'd0};
    assign db_wstrb    = 16'h00F0;
    assign db_wlast    = 1'b1;
    assign db_wvalid   = r_db_wvalid;
    assign db_bready   = r_db_bready;

    assign cpl_valid   = r_cpl_valid;
    assign cpl_cid     = r_cpl_cid;
    assign cpl_status  = r_cpl_status;

    assign cqdb_sqhead = r_sqhead;
    assign cqdb_cqhead = r_cqhead;
    assign err         = r_err;

endmodule

// File: tb/tb_cq_poller.sv
// Randomized bench for cq_poller: a CQ/doorbell responder plus a queue-level model of
// head, phase, SQ head and error state.
module tb_cq_poller;

    localparam int OUTSTANDING   = 16;
    localparam int CQ_ADDR_WIDTH = 8;
    localparam int POLL_GAP      = 8;
    localparam int DB_ADDR       = 1012;
    localparam int IW            = 4;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [CQ_ADDR_WIDTH-1:0] cq_araddr;
    logic [7:0]               cq_arlen;
    logic [2:0]               cq_arsize;
    logic [1:0]               cq_arburst;
    logic                     cq_arvalid;
    logic                     cq_arready = 1'b0;
    logic [127:0]             cq_rdata = '0;
    logic [1:0]               cq_rresp = '0;
    logic                     cq_rlast = 1'b0;
    logic                     cq_rvalid = 1'b0;
    logic                     cq_rready;
    logic [31:0]              db_awaddr;
    logic [7:0]               db_awlen;
    logic [2:0]               db_awsize;
    logic [1:0]               db_awburst;
    logic                     db_awvalid;
    logic                     db_awready = 1'b0;
    logic [127:0]             db_wdata;
    logic [15:0]              db_wstrb;
    logic                     db_wlast;
    logic                     db_wvalid;
    logic                     db_wready = 1'b0;
    logic [1:0]               db_bresp = '0;
    logic                     db_bvalid = 1'b0;
    logic                     db_bready;
    logic                     cpl_valid;
    logic                     cpl_ready = 1'b0;
    logic [15:0]              cpl_cid;
    logic [14:0]              cpl_status;
    logic [IW-1:0]            cqdb_sqhead;
    logic [IW-1:0]            cqdb_cqhead;
    logic                     err;

    cq_poller #(
        .OUTSTANDING   (OUTSTANDING),
        .CQ_ADDR_WIDTH (CQ_ADDR_WIDTH),
        .POLL_GAP      (POLL_GAP),
        .DB_ADDR       (DB_ADDR)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cq_araddr   (cq_araddr),
        .cq_arlen    (cq_arlen),
        .cq_arsize   (cq_arsize),
        .cq_arburst  (cq_arburst),
        .cq_arvalid  (cq_arvalid),
        .cq_arready  (cq_arready),
        .cq_rdata    (cq_rdata),
        .cq_rresp    (cq_rresp),
        .cq_rlast    (cq_rlast),
        .cq_rvalid   (cq_rvalid),
        .cq_rready   (cq_rready),
        .db_awaddr   (db_awaddr),
        .db_awlen    (db_awlen),
        .db_awsize   (db_awsize),
        .db_awburst  (db_awburst),
        .db_awvalid  (db_awvalid),
        .db_awready  (db_awready),
        .db_wdata    (db_wdata),
        .db_wstrb    (db_wstrb),
        .db_wlast    (db_wlast),
        .db_wvalid   (db_wvalid),
        .db_wready   (db_wready),
        .db_bresp    (db_bresp),
        .db_bvalid   (db_bvalid),
        .db_bready   (db_bready),
        .cpl_valid   (cpl_valid),
        .cpl_ready   (cpl_ready),
        .cpl_cid     (cpl_cid),
        .cpl_status  (cpl_status),
        .cqdb_sqhead (cqdb_sqhead),
        .cqdb_cqhead (cqdb_cqhead),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int aw_hs = 0;
    int w_hs = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (db_awvalid && db_awready) aw_hs <= aw_hs + 1;
        if (db_wvalid && db_wready)   w_hs  <= w_hs + 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    int m_head  = 0;
    bit m_phase = 1'b1;
    int m_sq    = 0;
    bit m_err   = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        rstn       = 1'b0;
        cq_arready = 1'b0;
        cq_rvalid  = 1'b0;
        db_awready = 1'b0;
        db_wready  = 1'b0;
        db_bvalid  = 1'b0;
        cpl_ready  = 1'b0;
        m_head  = 0;
        m_phase = 1'b1;
        m_sq    = 0;
        m_err   = 1'b0;
        repeat (cycles) @(negedge clk);
        check_val("rst_valids", {cq_arvalid, cq_rready, db_awvalid, db_wvalid, db_bready, cpl_valid}, 6'b0);
        check_val("rst_heads", {cqdb_cqhead, cqdb_sqhead}, '0);
        check_val("rst_err", err, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_ar_rise", cq_arvalid, 1'b1);
    endtask

    task automatic serve_poll(input logic [127:0] entry, input logic [1:0] resp, output int beat);
        int n = 0;
        while (!cq_arvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("ar_wait", cq_arvalid, 1'b1);
        check_val("araddr", cq_araddr, m_head * 16);
        check_val("ar_fields", {cq_arlen, cq_arsize, cq_arburst}, {8'd0, 3'd4, 2'd1});
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check_val("araddr_hold", {cq_arvalid, cq_araddr}, {1'b1, 8'(m_head * 16)});
        cq_arready = 1'b1;
        @(negedge clk);
        cq_arready = 1'b0;
        check_val("ar_drop", cq_arvalid, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check_val("rready", cq_rready, 1'b1);
        cq_rdata  = entry;
        cq_rresp  = resp;
        cq_rlast  = 1'b1;
        cq_rvalid = 1'b1;
        @(negedge clk);
        beat      = cyc;
        cq_rvalid = 1'b0;
        cq_rresp  = 2'd0;
        cq_rlast  = 1'b0;
        check_val("rready_drop", cq_rready, 1'b0);
    endtask

    task automatic check_gap(input int beat);
        int n = 0;
        bit saw_cpl = 1'b0;
        while (!cq_arvalid && n < 4 * POLL_GAP) begin
            if (cpl_valid) saw_cpl = 1'b1;
            @(negedge clk);
            n++;
        end
        check_val("gap_len", cyc - beat, POLL_GAP);
        check_val("gap_no_cpl", saw_cpl, 1'b0);
        check_val("gap_head", cqdb_cqhead, m_head);
    endtask

    task automatic do_cpl(input logic [15:0] cid, input logic [14:0] status, input logic [15:0] sq, input int hold);
        bit unstable = 1'b0;
        bit db_early = 1'b0;
        check_val("cpl_valid", cpl_valid, 1'b1);
        check_val("cpl_cid", cpl_cid, cid);
        check_val("cpl_status", cpl_status, status);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!cpl_valid || cpl_cid !== cid || cpl_status !== status) unstable = 1'b1;
            if (db_awvalid || db_wvalid) db_early = 1'b1;
        end
        check_val("cpl_stable", unstable, 1'b0);
        check_val("cpl_no_db", db_early, 1'b0);
        check_val("cpl_head_hold", cqdb_cqhead, m_head);
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
        m_head = (m_head + 1) % OUTSTANDING;
        if (m_head == 0) m_phase = ~m_phase;
        m_sq = sq % OUTSTANDING;
        check_val("cpl_drop", cpl_valid, 1'b0);
        check_val("cqhead", cqdb_cqhead, m_head);
        check_val("sqhead", cqdb_sqhead, m_sq);
    endtask

    task automatic do_db(input int mode, input logic [1:0] bresp);
        int aw0 = aw_hs;
        int w0  = w_hs;
        check_val("db_valids", {db_awvalid, db_wvalid}, 2'b11);
        check_val("db_awaddr", db_awaddr, DB_ADDR);
        check_val("db_aw_fields", {db_awlen, db_awsize, db_awburst}, {8'd0, 3'd2, 2'd1});
        check_val("db_wdata", db_wdata[63:32], m_head);
        check_val("db_wstrb_wlast", {db_wstrb, db_wlast}, {16'h00F0, 1'b1});
        repeat ($urandom_range(0, 2)) @(negedge clk);
        case (mode)
            1: begin
                db_wready = 1'b1;
                @(negedge clk);
                db_wready = 1'b0;
                check_val("db_w_first", {db_awvalid, db_wvalid}, 2'b10);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                db_awready = 1'b1;
                @(negedge clk);
                db_awready = 1'b0;
            end
            2: begin
                db_awready = 1'b1;
                @(negedge clk);
                db_awready = 1'b0;
                check_val("db_aw_first", {db_awvalid, db_wvalid}, 2'b01);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                db_wready = 1'b1;
                @(negedge clk);
                db_wready = 1'b0;
            end
            default: begin
                db_awready = 1'b1;
                db_wready  = 1'b1;
                @(negedge clk);
                db_awready = 1'b0;
                db_wready  = 1'b0;
            end
        endcase
        check_val("db_done_valids", {db_awvalid, db_wvalid}, 2'b00);
        check_val("bready", db_bready, 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check_val("db_hs_count", {16'(aw_hs - aw0), 16'(w_hs - w0)}, {16'd1, 16'd1});
        db_bresp  = bresp;
        db_bvalid = 1'b1;
        @(negedge clk);
        db_bvalid = 1'b0;
        db_bresp  = 2'd0;
        check_val("bready_drop", db_bready, 1'b0);
    endtask

    task automatic run_txn(input bit accept, input logic [15:0] cid, input logic [14:0] status,
                           input logic [15:0] sq, input int mode, input int hold,
                           input logic [1:0] rresp, input logic [1:0] bresp);
        logic [127:0] entry;
        int beat;
        entry = {$urandom, $urandom, $urandom, $urandom};
        entry[127:113] = status;
        entry[112]     = accept ? m_phase : ~m_phase;
        entry[111:96]  = cid;
        entry[79:64]   = sq;
        serve_poll(entry, rresp, beat);
        if (rresp != 2'd0) m_err = 1'b1;
        if (accept) begin
            do_cpl(cid, status, sq, hold);
            do_db(mode, bresp);
            if (bresp != 2'd0) m_err = 1'b1;
        end else begin
            check_gap(beat);
        end
        check_val("err", err, m_err);
        $display("txn accept=%0d cid=%04h head=%0d phase=%0d sq=%0d err=%0d", accept, cid, m_head, m_phase, m_sq, m_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        logic [127:0] entry;
        reset_dut(3);

        // Stale entry at index 0, then the canonical first completion.
        run_txn(1'b0, 16'h1111, 15'h0, 16'd9, 0, 0, 2'd0, 2'd0);
        run_txn(1'b1, 16'h0005, 15'h0, 16'd3, 0, 0, 2'd0, 2'd0);

        // Doorbell channel ordering and a long cpl_ready stall.
        run_txn(1'b1, 16'(($urandom)), 15'($urandom), 16'($urandom), 1, 0, 2'd0, 2'd0);
        run_txn(1'b1, 16'(($urandom)), 15'($urandom), 16'($urandom), 2, 0, 2'd0, 2'd0);
        run_txn(1'b1, 16'(($urandom)), 15'($urandom), 16'($urandom), 0, 20, 2'd0, 2'd0);

        // Random mix long enough to wrap the CQ at least twice.
        for (int i = 0; i < 45; i++) begin
            run_txn(($urandom_range(0, 3) != 0), 16'($urandom), 15'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2'd0, 2'd0);
        end

        // Bus error is sticky across further traffic.
        run_txn(1'b0, 16'h2222, 15'h0, 16'd0, 0, 0, 2'd2, 2'd0);
        run_txn(1'b1, 16'h3333, 15'h1, 16'd7, 0, 0, 2'd0, 2'd0);

        // Reset while a completion is pending: no replay, restart at head 0 with phase 1.
        entry = {$urandom, $urandom, $urandom, $urandom};
        entry[112] = m_phase;
        serve_poll(entry, 2'd0, beat);
        check_val("pending_cpl", cpl_valid, 1'b1);
        reset_dut(2);
        run_txn(1'b0, 16'h4444, 15'h0, 16'd0, 0, 0, 2'd0, 2'd0);
        run_txn(1'b1, 16'h0042, 15'h2, 16'd5, 0, 0, 2'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
